// File: rtl/multi_cycle_controller.sv
// Main FSM and instruction decode for the multi-cycle RV32I datapath.
// Sequences fetch/decode/execute/memory/writeback over one shared ALU and memory.
module multi_cycle_controller #(
    parameter logic [6:0] HALT_OP = 7'b0000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       Zero,
    input  logic       Neg,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       RegWrite,
    output logic       done
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite, StExecR, StExecI,
        StAluWb, StJal, StJalr1, StJalr2, StBranch, StLui, StHalt
    } state_e;

    state_e state_q, state_d;
    logic [2:0] imm_fmt;
    logic       branch_taken;

    function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub_en);
        case (f3)
            3'b000:  return sub_en ? 3'b001 : 3'b000;
            3'b111:  return 3'b010;
            3'b110:  return 3'b011;
            3'b100:  return 3'b100;
            3'b010:  return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        case (op)
            OpStore:  imm_fmt = 3'b001;
            OpBranch: imm_fmt = 3'b010;
            OpJal:    imm_fmt = 3'b011;
            OpLui:    imm_fmt = 3'b100;
            default:  imm_fmt = 3'b000;
        endcase
    end

    always_comb begin
        case (func3)
            3'b000:  branch_taken = Zero;
            3'b001:  branch_taken = !Zero;
            3'b100:  branch_taken = Neg;
            3'b101:  branch_taken = !Neg;
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = 3'b000;
        ImmSrc     = imm_fmt;
        RegWrite   = 1'b0;
        done       = 1'b0;
        case (state_q)
            StFetch: begin
                IRWrite   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
                state_d   = StDecode;
            end
            StDecode: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:         state_d = StExecR;
                    OpIType:         state_d = StExecI;
                    OpJal:           state_d = StJal;
                    OpJalr:          state_d = StJalr1;
                    OpBranch:        state_d = StBranch;
                    OpLui:           state_d = StLui;
                    default:         state_d = (op == HALT_OP) ? StHalt : StFetch;
                endcase
            end
            StMemAdr: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = (op == OpStore) ? 3'b001 : 3'b000;
                state_d = (op == OpStore) ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                AdrSrc  = 1'b1;
                state_d = StMemWb;
            end
            StMemWb: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                state_d   = StFetch;
            end
            StMemWrite: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                state_d  = StFetch;
            end
            StExecR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_dec(func3, func7 == 7'b0100000);
                state_d    = StAluWb;
            end
            StExecI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ImmSrc     = 3'b000;
                ALUControl = alu_dec(func3, 1'b0);
                state_d    = StAluWb;
            end
            StAluWb: begin
                RegWrite = 1'b1;
                state_d  = StFetch;
            end
            StJal, StJalr2: begin
                // Target already in ALUOut; ALU now forms the link value OldPC+4.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                state_d = StAluWb;
            end
            StJalr1: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = 3'b000;
                state_d = StJalr2;
            end
            StBranch: begin
                ALUSrcA    = 2'b10;
                ALUControl = 3'b001;
                PCWrite    = branch_taken;
                state_d    = StFetch;
            end
            StLui: begin
                ImmSrc    = 3'b100;
                ResultSrc = 2'b11;
                RegWrite  = 1'b1;
                state_d   = StFetch;
            end
            StHalt: begin
                done    = 1'b1;
                state_d = StHalt;
            end
            default: state_d = StFetch;
        endcase
        // Reset masks the FETCH enables that the forced state would otherwise drive.
        if (!rst) begin
            PCWrite  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            done     = 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed, table-driven bench for multi_cycle_controller: one table row per clock cycle.
module tb_multi_cycle_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] op = 7'd0;
    logic [2:0] func3 = 3'd0;
    logic [6:0] func7 = 7'd0;
    logic       Zero = 1'b0;
    logic       Neg = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, done;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ALUControl, ImmSrc;

    int n_cmp = 0;
    int n_bad = 0;

    multi_cycle_controller #(.HALT_OP(7'b0000000)) dut (
        .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7), .Zero(Zero), .Neg(Neg),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .ImmSrc(ImmSrc), .RegWrite(RegWrite), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        z;
        logic        n;
        logic [17:0] exp;
    } vec_t;

    vec_t vecs[$];

    // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,ImmSrc,RegWrite,done}
    function automatic logic [17:0] o(input logic pcw, input logic adr, input logic mw,
                                      input logic irw, input logic [1:0] rs,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [2:0] alu, input logic [2:0] imm,
                                      input logic rw, input logic dn);
        return {pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw, dn};
    endfunction

    function automatic logic [17:0] fetch_o(input logic [2:0] imm);
        return o(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'd0, imm, 0, 0);
    endfunction
    function automatic logic [17:0] decode_o(input logic [2:0] imm);
        return o(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'd0, imm, 0, 0);
    endfunction
    function automatic logic [17:0] aluwb_o(input logic [2:0] imm);
        return o(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'd0, imm, 1, 0);
    endfunction

    function automatic logic [17:0] outs();
        return {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl,
                ImmSrc, RegWrite, done};
    endfunction

    task automatic push(input string name, input logic [6:0] op_v, input logic [2:0] f3,
                        input logic [6:0] f7, input logic z, input logic n,
                        input logic [17:0] exp);
        vec_t v;
        v.name = name; v.op = op_v; v.f3 = f3; v.f7 = f7; v.z = z; v.n = n; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs, check outputs mid-cycle, then advance past the edge.
    task automatic run(input vec_t v);
        op = v.op; func3 = v.f3; func7 = v.f7; Zero = v.z; Neg = v.n;
        @(negedge clk);
        check(v.name, outs(), v.exp);
        @(posedge clk);
        #1;
    endtask

    task automatic enables_low(input string name);
        n_cmp++;
        if ({PCWrite, MemWrite, IRWrite, RegWrite, done} !== 5'b0) begin
            n_bad++;
            $display("FAIL %s: enables/done got %b, expected 00000", name,
                     {PCWrite, MemWrite, IRWrite, RegWrite, done});
        end
    endtask

    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LW = 7'b0000011, SW = 7'b0100011;
    localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;
    localparam logic [6:0] LUI = 7'b0110111, ILL = 7'b1111111, HLT = 7'b0000000;

    initial begin
        // add / sub / and
        push("add.fetch", R, 3'b000, 7'h00, 0, 0, fetch_o(0));
        push("add.decode", R, 3'b000, 7'h00, 0, 0, decode_o(0));
        push("add.execr", R, 3'b000, 7'h00, 0, 0, o(0,0,0,0,2'b00,2'b10,2'b00,3'b000,0,0,0));
        push("add.aluwb", R, 3'b000, 7'h00, 0, 0, aluwb_o(0));
        push("sub.fetch", R, 3'b000, 7'h20, 0, 0, fetch_o(0));
        push("sub.decode", R, 3'b000, 7'h20, 0, 0, decode_o(0));
        push("sub.execr", R, 3'b000, 7'h20, 0, 0, o(0,0,0,0,2'b00,2'b10,2'b00,3'b001,0,0,0));
        push("sub.aluwb", R, 3'b000, 7'h20, 0, 0, aluwb_o(0));
        push("and.fetch", R, 3'b111, 7'h00, 0, 0, fetch_o(0));
        push("and.decode", R, 3'b111, 7'h00, 0, 0, decode_o(0));
        push("and.execr", R, 3'b111, 7'h00, 0, 0, o(0,0,0,0,2'b00,2'b10,2'b00,3'b010,0,0,0));
        push("and.aluwb", R, 3'b111, 7'h00, 0, 0, aluwb_o(0));
        // addi with f7=0100000 must still add; slti selects slt
        push("addi.fetch", I, 3'b000, 7'h20, 0, 0, fetch_o(0));
        push("addi.decode", I, 3'b000, 7'h20, 0, 0, decode_o(0));
        push("addi.execi", I, 3'b000, 7'h20, 0, 0, o(0,0,0,0,2'b00,2'b10,2'b01,3'b000,0,0,0));
        push("addi.aluwb", I, 3'b000, 7'h20, 0, 0, aluwb_o(0));
        push("slti.fetch", I, 3'b010, 7'h00, 0, 0, fetch_o(0));
        push("slti.decode", I, 3'b010, 7'h00, 0, 0, decode_o(0));
        push("slti.execi", I, 3'b010, 7'h00, 0, 0, o(0,0,0,0,2'b00,2'b10,2'b01,3'b101,0,0,0));
        push("slti.aluwb", I, 3'b010, 7'h00, 0, 0, aluwb_o(0));
        // lw: 5 cycles
        push("lw.fetch", LW, 3'b010, 7'h00, 0, 0, fetch_o(0));
        push("lw.decode", LW, 3'b010, 7'h00, 0, 0, decode_o(0));
        push("lw.memadr", LW, 3'b010, 7'h00, 0, 0, o(0,0,0,0,2'b00,2'b10,2'b01,3'b000,0,0,0));
        push("lw.memread", LW, 3'b010, 7'h00, 0, 0, o(0,1,0,0,2'b00,2'b00,2'b00,3'b000,0,0,0));
        push("lw.memwb", LW, 3'b010, 7'h00, 0, 0, o(0,0,0,0,2'b01,2'b00,2'b00,3'b000,0,1,0));
        // sw: 4 cycles, S immediate
        push("sw.fetch", SW, 3'b010, 7'h00, 0, 0, fetch_o(1));
        push("sw.decode", SW, 3'b010, 7'h00, 0, 0, decode_o(1));
        push("sw.memadr", SW, 3'b010, 7'h00, 0, 0, o(0,0,0,0,2'b00,2'b10,2'b01,3'b000,1,0,0));
        push("sw.memwrite", SW, 3'b010, 7'h00, 0, 0, o(0,1,1,0,2'b00,2'b00,2'b00,3'b000,1,0,0));
        // branches: beq taken/not, blt taken, bge not taken on Neg, bne taken
        push("beq1.fetch", BR, 3'b000, 7'h00, 0, 0, fetch_o(2));
        push("beq1.decode", BR, 3'b000, 7'h00, 0, 0, decode_o(2));
        push("beq1.branch", BR, 3'b000, 7'h00, 1, 0, o(1,0,0,0,2'b00,2'b10,2'b00,3'b001,2,0,0));
        push("beq0.fetch", BR, 3'b000, 7'h00, 0, 0, fetch_o(2));
        push("beq0.decode", BR, 3'b000, 7'h00, 0, 0, decode_o(2));
        push("beq0.branch", BR, 3'b000, 7'h00, 0, 0, o(0,0,0,0,2'b00,2'b10,2'b00,3'b001,2,0,0));
        push("blt.fetch", BR, 3'b100, 7'h00, 0, 0, fetch_o(2));
        push("blt.decode", BR, 3'b100, 7'h00, 0, 0, decode_o(2));
        push("blt.branch", BR, 3'b100, 7'h00, 0, 1, o(1,0,0,0,2'b00,2'b10,2'b00,3'b001,2,0,0));
        push("bge.fetch", BR, 3'b101, 7'h00, 0, 0, fetch_o(2));
        push("bge.decode", BR, 3'b101, 7'h00, 0, 0, decode_o(2));
        push("bge.branch", BR, 3'b101, 7'h00, 0, 1, o(0,0,0,0,2'b00,2'b10,2'b00,3'b001,2,0,0));
        push("bne.fetch", BR, 3'b001, 7'h00, 0, 0, fetch_o(2));
        push("bne.decode", BR, 3'b001, 7'h00, 0, 0, decode_o(2));
        push("bne.branch", BR, 3'b001, 7'h00, 0, 0, o(1,0,0,0,2'b00,2'b10,2'b00,3'b001,2,0,0));
        // jal: 4 cycles
        push("jal.fetch", JAL, 3'b000, 7'h00, 0, 0, fetch_o(3));
        push("jal.decode", JAL, 3'b000, 7'h00, 0, 0, decode_o(3));
        push("jal.jal", JAL, 3'b000, 7'h00, 0, 0, o(1,0,0,0,2'b00,2'b01,2'b10,3'b000,3,0,0));
        push("jal.aluwb", JAL, 3'b000, 7'h00, 0, 0, aluwb_o(3));
        // jalr: 5 cycles
        push("jalr.fetch", JALR, 3'b000, 7'h00, 0, 0, fetch_o(0));
        push("jalr.decode", JALR, 3'b000, 7'h00, 0, 0, decode_o(0));
        push("jalr.jalr1", JALR, 3'b000, 7'h00, 0, 0, o(0,0,0,0,2'b00,2'b10,2'b01,3'b000,0,0,0));
        push("jalr.jalr2", JALR, 3'b000, 7'h00, 0, 0, o(1,0,0,0,2'b00,2'b01,2'b10,3'b000,0,0,0));
        push("jalr.aluwb", JALR, 3'b000, 7'h00, 0, 0, aluwb_o(0));
        // lui: 3 cycles
        push("lui.fetch", LUI, 3'b000, 7'h00, 0, 0, fetch_o(4));
        push("lui.decode", LUI, 3'b000, 7'h00, 0, 0, decode_o(4));
        push("lui.lui", LUI, 3'b000, 7'h00, 0, 0, o(0,0,0,0,2'b11,2'b00,2'b00,3'b000,4,1,0));
        // illegal: 2 cycles, no writes, then straight back to FETCH
        push("ill.fetch", ILL, 3'b000, 7'h00, 0, 0, fetch_o(0));
        push("ill.decode", ILL, 3'b000, 7'h00, 0, 0, decode_o(0));
        push("ill.next_fetch", LUI, 3'b000, 7'h00, 0, 0, fetch_o(4));
        push("ill.next_decode", LUI, 3'b000, 7'h00, 0, 0, decode_o(4));
        push("ill.next_lui", LUI, 3'b000, 7'h00, 0, 0, o(0,0,0,0,2'b11,2'b00,2'b00,3'b000,4,1,0));

        // Reset held: enables and done low
        repeat (2) @(posedge clk);
        @(negedge clk);
        enables_low("reset.held");
        @(posedge clk);
        #1 rst = 1'b1;

        foreach (vecs[i]) run(vecs[i]);

        // Abort lw mid-instruction with an asynchronous reset
        for (int i = 20; i < 23; i++) run(vecs[i]);
        #2 rst = 1'b0;
        #1 enables_low("abort.in_reset");
        @(posedge clk);
        #1 rst = 1'b1;
        run(vecs[0]);
        run(vecs[1]);
        run(vecs[2]);
        run(vecs[3]);

        // Halt: done held with all enables low, then reset restarts at FETCH
        begin
            vec_t h;
            h.op = HLT; h.f3 = 3'b000; h.f7 = 7'h00; h.z = 1'b1; h.n = 1'b1;
            h.name = "halt.fetch";  h.exp = fetch_o(0);  run(h);
            h.name = "halt.decode"; h.exp = decode_o(0); run(h);
            h.name = "halt.hold";
            h.exp = o(0,0,0,0,2'b00,2'b00,2'b00,3'b000,0,0,1);
            for (int i = 0; i < 20; i++) run(h);
        end
        #2 rst = 1'b0;
        #1 enables_low("halt.reset_clears_done");
        @(posedge clk);
        #1 rst = 1'b1;
        run(vecs[53]);
        run(vecs[54]);
        run(vecs[55]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
